div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
Parameters: none; datapath width fixed at 32 bits.
REQ-001 clock  input  1  Single clock; all state updates on rising edge.
REQ-002 reset  input  1  Asynchronous, active-low reset; low clears all state immediately, independent of clock.
REQ-003 data_operandA  input  32  Dividend, two's complement, sampled only on the start edge.
REQ-004 data_operandB  input  32  Divisor, two's complement, sampled only on the start edge.
REQ-005 ctrl_DIV  input  1  Start request, level-sampled at rising edge.
REQ-006 data_result  output  32  Signed quotient, truncated toward zero.
REQ-007 data_remainder  output  32  Signed remainder; sign equals dividend sign, or zero.
REQ-008 data_exception  output  1  High with result when divisor was zero.
REQ-009 data_resultRDY  output  1  One-cycle pulse marking data_result/data_remainder/data_exception valid.

Function
REQ-010 The block SHALL be a restoring iterative divider with states IDLE, RUN, FIX, DONE.
REQ-011 IDLE: ctrl_DIV=1 at an edge (start edge E0) SHALL latch |A|, |B|, sign(A), sign(B), B==0, load 5-bit iteration counter with 0, and enter RUN.
REQ-012 RUN: each edge SHALL shift {rem,quot} left 1, trial-subtract |B| from the upper 33 bits, keep the difference and set quot LSB=1 if non-negative, else restore and set LSB=0; counter increments.
REQ-013 RUN SHALL last exactly 32 edges (E1..E32); the edge at which counter==31 SHALL transition to FIX.
REQ-014 FIX (edge E33): quotient SHALL be negated if sign(A)!=sign(B); remainder SHALL be negated if sign(A)=1; results registered to outputs; enter DONE.
REQ-015 DONE: data_resultRDY SHALL be 1 for exactly the one cycle following E33; next edge returns to IDLE.
REQ-016 Latency SHALL be fixed at 33 edges from start edge to data_resultRDY high, for all operand values including exceptions.
REQ-017 Absolute values SHALL use 33-bit internal arithmetic so |0x80000000| is represented without overflow.
REQ-018 Divisor zero: data_exception=1, data_result=0x00000000, data_remainder=0x00000000, same latency.
REQ-019 0x80000000 / 0xFFFFFFFF: data_result=0x80000000 (wrap), data_remainder=0, data_exception=0.
REQ-020 ctrl_DIV while in RUN, FIX or DONE SHALL be ignored; no queuing; operand changes after E0 SHALL not affect the result.
REQ-021 ctrl_DIV=1 in the same cycle data_resultRDY is high SHALL be ignored; a start is accepted only in IDLE.
REQ-022 data_result, data_remainder, data_exception SHALL hold their last values until the next FIX edge overwrites them.
REQ-023 data_exception SHALL be 0 for every non-zero divisor.

Reset
REQ-024 reset low SHALL force state IDLE, counter 0, data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, asynchronously.
REQ-025 reset low during RUN/FIX SHALL abort the operation; no data_resultRDY pulse for it.
REQ-026 First start SHALL be accepted at the first rising edge with reset high and ctrl_DIV=1.

Verification
REQ-027 A=7, B=2, start -> 33 edges later RDY pulse one cycle, result=3, remainder=1, exception=0.
REQ-028 A=-7 (0xFFFFFFF9), B=2 -> result=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); A=7, B=-2 -> result=-3, remainder=1.
REQ-029 A=5, B=0 -> RDY at edge 33, exception=1, result=0, remainder=0; then A=5, B=1 -> exception=0, result=5.
REQ-030 A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, remainder=0, exception=0; A=0x80000000, B=1 -> result=0x80000000.
REQ-031 Start A=100, B=7; pulse ctrl_DIV with A=1, B=1 at edges 10 and 33 -> single RDY at edge 33, result=14, remainder=2; no second RDY.
REQ-032 Start A=100, B=7; assert reset low at edge 15 for one cycle -> outputs 0 immediately, no RDY; new start A=9, B=3 -> result=3 after 33 edges.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: 32-bit signed restoring divider, fixed 33-edge latency.
// Quotient truncates toward zero; remainder follows dividend sign.
module div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic [31:0] data_remainder,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quot;
  logic [32:0] bmag;
  logic        sign_a;
  logic        sign_b;
  logic        b_zero;

  logic [32:0] a_ext;
  logic [32:0] b_ext;
  logic [32:0] amag;
  logic [32:0] bmag_in;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        borrow;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        unused_bits;

  // 33-bit magnitudes so |0x80000000| stays positive
  assign a_ext   = {data_operandA[31], data_operandA};
  assign b_ext   = {data_operandB[31], data_operandB};
  assign amag    = a_ext[32] ? -a_ext : a_ext;
  assign bmag_in = b_ext[32] ? -b_ext : b_ext;

  assign shifted        = {rem, quot[31]};
  assign {borrow, diff} = {1'b0, shifted} - {1'b0, bmag};

  assign q_fix = (sign_a ^ sign_b) ? -quot : quot;
  assign r_fix = sign_a ? -rem : rem;

  assign unused_bits = ^{amag[32], diff[32]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      quot           <= '0;
      bmag           <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      b_zero         <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ctrl_DIV) begin
            rem    <= '0;
            quot   <= amag[31:0];
            bmag   <= bmag_in;
            sign_a <= data_operandA[31];
            sign_b <= data_operandB[31];
            b_zero <= (data_operandB == 32'd0);
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          rem  <= borrow ? shifted[31:0] : diff[31:0];
          quot <= {quot[30:0], ~borrow};
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= FIX;
        end
        FIX: begin
          data_result    <= b_zero ? 32'd0 : q_fix;
          data_remainder <= b_zero ? 32'd0 : r_fix;
          data_exception <= b_zero;
          data_resultRDY <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit results, latency,
// start filtering and asynchronous reset abort.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] opa   = '0;
  logic [31:0] opb   = '0;
  logic        start = 1'b0;
  logic [31:0] res;
  logic [31:0] rem;
  logic        exc;
  logic        rdy;

  int total = 0;
  int bad   = 0;

  div_unit dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (opa),
    .data_operandB (opb),
    .ctrl_DIV      (start),
    .data_result   (res),
    .data_remainder(rem),
    .data_exception(exc),
    .data_resultRDY(rdy)
  );

  always #5 clock = ~clock;

  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q,
                        output logic [31:0] r, output logic e,
                        output logic rdy_after);
    @(posedge clock); #1;
    opa = a; opb = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    opa = 32'h1234_5678; opb = 32'h0000_0003;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (rdy) begin
        lat = k;
        break;
      end
    end
    q = res; r = rem; e = exc;
    @(posedge clock); #1;
    rdy_after = rdy;
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b0; start = 1'b1; opa = 32'd20; opb = 32'd6;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({res, rem, exc, rdy} !== 66'd0) begin
      bad++;
      $display("FAIL reset_outputs res=%h rem=%h exc=%b rdy=%b want all 0",
               res, rem, exc, rdy);
    end
    reset = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (rdy) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat !== 34) begin
      bad++;
      $display("FAIL first_start_latency got=%0d want=34", lat);
    end
    total++;
    if (res !== 32'd3 || rem !== 32'd2 || exc !== 1'b0) begin
      bad++;
      $display("FAIL first_start_result res=%h rem=%h exc=%b want 3 2 0",
               res, rem, exc);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_signs();
    int lat;
    logic [31:0] q, r;
    logic e, ra;
    do_div(32'd7, 32'd2, lat, q, r, e, ra);
    total++;
    if (lat !== 33 || ra !== 1'b0) begin
      bad++;
      $display("FAIL pos_latency got=%0d rdy_after=%b want 33 0", lat, ra);
    end
    total++;
    if (q !== 32'd3 || r !== 32'd1 || e !== 1'b0) begin
      bad++;
      $display("FAIL pos_div q=%h r=%h e=%b want 3 1 0", q, r, e);
    end
    do_div(32'hFFFF_FFF9, 32'd2, lat, q, r, e, ra);
    total++;
    if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || e !== 1'b0) begin
      bad++;
      $display("FAIL neg_dividend q=%h r=%h e=%b want fffffffd ffffffff 0",
               q, r, e);
    end
    do_div(32'd7, 32'hFFFF_FFFE, lat, q, r, e, ra);
    total++;
    if (q !== 32'hFFFF_FFFD || r !== 32'd1 || e !== 1'b0) begin
      bad++;
      $display("FAIL neg_divisor q=%h r=%h e=%b want fffffffd 1 0", q, r, e);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [31:0] q, r;
    logic e, ra;
    do_div(32'd5, 32'd0, lat, q, r, e, ra);
    total++;
    if (lat !== 33) begin
      bad++;
      $display("FAIL zero_latency got=%0d want=33", lat);
    end
    total++;
    if (q !== 32'd0 || r !== 32'd0 || e !== 1'b1) begin
      bad++;
      $display("FAIL div_zero q=%h r=%h e=%b want 0 0 1", q, r, e);
    end
    do_div(32'd5, 32'd1, lat, q, r, e, ra);
    total++;
    if (q !== 32'd5 || r !== 32'd0 || e !== 1'b0) begin
      bad++;
      $display("FAIL after_zero q=%h r=%h e=%b want 5 0 0", q, r, e);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] q, r;
    logic e, ra;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, e, ra);
    total++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || e !== 1'b0) begin
      bad++;
      $display("FAIL min_by_m1 q=%h r=%h e=%b want 80000000 0 0", q, r, e);
    end
    do_div(32'h8000_0000, 32'd1, lat, q, r, e, ra);
    total++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || e !== 1'b0) begin
      bad++;
      $display("FAIL min_by_1 q=%h r=%h e=%b want 80000000 0 0", q, r, e);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nrdy;
    logic [31:0] q, r;
    @(posedge clock); #1;
    opa = 32'd100; opb = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; opa = 32'd1; opb = 32'd1;
    lat = 0; nrdy = 0; q = '0; r = '0;
    for (int k = 1; k <= 75; k++) begin
      @(posedge clock); #1;
      if (rdy) begin
        nrdy++;
        if (lat == 0) begin
          lat = k; q = res; r = rem;
        end
      end
      start = (k == 9 || k == 32 || k == 33);
    end
    start = 1'b0;
    total++;
    if (nrdy !== 1 || lat !== 33) begin
      bad++;
      $display("FAIL ignore_start rdy_count=%0d lat=%0d want 1 33", nrdy, lat);
    end
    total++;
    if (q !== 32'd14 || r !== 32'd2) begin
      bad++;
      $display("FAIL ignore_result q=%h r=%h want e 2", q, r);
    end
    total++;
    if (res !== 32'd14 || rem !== 32'd2 || exc !== 1'b0) begin
      bad++;
      $display("FAIL hold_outputs res=%h rem=%h exc=%b want e 2 0",
               res, rem, exc);
    end
  endtask

  task automatic test_reset_abort();
    int lat, nrdy;
    logic [31:0] q, r;
    logic e, ra;
    @(posedge clock); #1;
    opa = 32'd100; opb = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({res, rem, exc, rdy} !== 66'd0) begin
      bad++;
      $display("FAIL abort_clear res=%h rem=%h exc=%b rdy=%b want all 0",
               res, rem, exc, rdy);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    nrdy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (rdy) nrdy++;
    end
    total++;
    if (nrdy !== 0) begin
      bad++;
      $display("FAIL abort_no_rdy rdy_count=%0d want 0", nrdy);
    end
    do_div(32'd9, 32'd3, lat, q, r, e, ra);
    total++;
    if (lat !== 33 || q !== 32'd3 || r !== 32'd0 || e !== 1'b0) begin
      bad++;
      $display("FAIL after_abort lat=%0d q=%h r=%h e=%b want 33 3 0 0",
               lat, q, r, e);
    end
  endtask

  initial begin
    test_reset();
    test_signs();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
